// File: rtl/alu_control_unit.sv
// Multi-cycle fetch/decode/execute sequencer driving the 8-bit ALU and register file.
// Optional fetch timeout with sticky FetchFault is enabled by defining INSTR_TIMEOUT_EN.
module alu_control_unit #(
    parameter int PC_WIDTH       = 8,
    parameter int ALUSEL_WIDTH   = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    Start,
    input  logic [7:0]              InstrData,
    input  logic                    InstrValid,
    input  logic                    CF,
    input  logic                    ZF,
    output logic [PC_WIDTH-1:0]     PC,
    output logic                    InstrReq,
    output logic [ALUSEL_WIDTH-1:0] ALUSel,
    output logic                    WriteCZ,
    output logic [1:0]              RegSrcA,
    output logic [1:0]              RegSrcB,
    output logic                    RegWrite,
    output logic                    Busy,
    output logic                    Halted,
`ifdef INSTR_TIMEOUT_EN
    output logic                    FetchFault,
`endif
    output logic                    IllegalOp
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT
    } state_t;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t              state;
    logic [7:0]          ir;
    logic [3:0]          op;
    logic                is_alu;
    logic                is_ill;
    logic                is_halt;
    logic                taken;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] pc_br;

`ifdef INSTR_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;
`endif

    always_comb begin
        op      = ir[7:4];
        is_alu  = (op <= 4'd9);
        is_ill  = (op == 4'hD) || (op == 4'hE);
        is_halt = (op == 4'hF);
        taken   = ((op == 4'hA) && ZF) || ((op == 4'hB) && CF);
        pc_inc  = PC + PC_WIDTH'(1);
        pc_br   = pc_inc + PC_WIDTH'(ir[3:0]);
    end

    // Outputs are registered: each transition loads the values for the state being entered.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= S_IDLE;
            PC        <= '0;
            ir        <= '0;
            InstrReq  <= 1'b0;
            ALUSel    <= '0;
            WriteCZ   <= 1'b0;
            RegSrcA   <= 2'd0;
            RegSrcB   <= 2'd0;
            RegWrite  <= 1'b0;
            Busy      <= 1'b0;
            Halted    <= 1'b0;
            IllegalOp <= 1'b0;
`ifdef INSTR_TIMEOUT_EN
            FetchFault <= 1'b0;
            tcnt       <= '0;
`endif
        end else begin
            ALUSel    <= '0;
            WriteCZ   <= 1'b0;
            RegWrite  <= 1'b0;
            IllegalOp <= 1'b0;
            unique case (state)
                S_IDLE, S_HALT: begin
                    if (Start) begin
                        state    <= S_FETCH;
                        PC       <= '0;
                        InstrReq <= 1'b1;
                        Busy     <= 1'b1;
                        Halted   <= 1'b0;
`ifdef INSTR_TIMEOUT_EN
                        FetchFault <= 1'b0;
                        tcnt       <= '0;
`endif
                    end
                end
                S_FETCH: begin
                    if (InstrValid) begin
                        state    <= S_DECODE;
                        ir       <= InstrData;
                        InstrReq <= 1'b0;
                        RegSrcA  <= InstrData[3:2];
                        RegSrcB  <= InstrData[1:0];
                    end
`ifdef INSTR_TIMEOUT_EN
                    else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        state      <= S_HALT;
                        InstrReq   <= 1'b0;
                        Busy       <= 1'b0;
                        Halted     <= 1'b1;
                        FetchFault <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
`endif
                end
                S_DECODE: begin
                    state <= S_EXEC;
                    if (is_alu) begin
                        ALUSel   <= ALUSEL_WIDTH'(op);
                        WriteCZ  <= 1'b1;
                        RegWrite <= 1'b1;
                    end
                    IllegalOp <= is_ill;
                end
                S_EXEC: begin
                    if (is_halt) begin
                        state  <= S_HALT;
                        Busy   <= 1'b0;
                        Halted <= 1'b1;
                    end else begin
                        state    <= S_FETCH;
                        InstrReq <= 1'b1;
                        PC       <= taken ? pc_br : pc_inc;
`ifdef INSTR_TIMEOUT_EN
                        tcnt <= '0;
`endif
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    InstrReq <= 1'b0;
                    Busy     <= 1'b0;
                    Halted   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_control_unit.sv
// Directed bench for alu_control_unit with a small instruction memory model.
// Build with INSTR_TIMEOUT_EN defined to also exercise the fetch timeout.
module tb_alu_control_unit;

    logic       Clk;
    logic       Rst;
    logic       Start;
    logic [7:0] InstrData;
    logic       InstrValid;
    logic       CF;
    logic       ZF;
    logic [7:0] PC;
    logic       InstrReq;
    logic [3:0] ALUSel;
    logic       WriteCZ;
    logic [1:0] RegSrcA;
    logic [1:0] RegSrcB;
    logic       RegWrite;
    logic       Busy;
    logic       Halted;
    logic       IllegalOp;
`ifdef INSTR_TIMEOUT_EN
    logic       FetchFault;
`endif

    logic [7:0] mem [256];
    int errors = 0;
    int checks = 0;

    alu_control_unit #(
        .PC_WIDTH(8),
        .ALUSEL_WIDTH(4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .Start(Start),
        .InstrData(InstrData),
        .InstrValid(InstrValid),
        .CF(CF),
        .ZF(ZF),
        .PC(PC),
        .InstrReq(InstrReq),
        .ALUSel(ALUSel),
        .WriteCZ(WriteCZ),
        .RegSrcA(RegSrcA),
        .RegSrcB(RegSrcB),
        .RegWrite(RegWrite),
        .Busy(Busy),
        .Halted(Halted),
`ifdef INSTR_TIMEOUT_EN
        .FetchFault(FetchFault),
`endif
        .IllegalOp(IllegalOp)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    assign InstrData = mem[PC];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic run_instr();
        tick();
        tick();
        tick();
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'hC0;
    endtask

    task automatic restart();
        Rst = 1'b1;
        tick();
        Rst   = 1'b0;
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    initial begin
        int nreq;
        logic wsum;
        Rst = 1'b1;
        Start = 1'b0;
        InstrValid = 1'b0;
        CF = 1'b0;
        ZF = 1'b0;
        clear_mem();
        tick();
        tick();
        check("rst_pc", PC, 0);
        check("rst_req", InstrReq, 0);
        check("rst_alusel", ALUSel, 0);
        check("rst_wcz", WriteCZ, 0);
        check("rst_rw", RegWrite, 0);
        check("rst_busy", Busy, 0);
        check("rst_halt", Halted, 0);

        // ADD R1,R2 with zero wait
        mem[0] = 8'h46;
        InstrValid = 1'b1;
        restart();
        check("f_req", InstrReq, 1);
        check("f_busy", Busy, 1);
        check("f_pc", PC, 0);
        tick();
        check("d_srca", RegSrcA, 1);
        check("d_srcb", RegSrcB, 2);
        check("d_wcz", WriteCZ, 0);
        check("d_req", InstrReq, 0);
        tick();
        check("e_alusel", ALUSel, 4'b0100);
        check("e_wcz", WriteCZ, 1);
        check("e_rw", RegWrite, 1);
        check("e_srca", RegSrcA, 1);
        tick();
        check("n_wcz", WriteCZ, 0);
        check("n_rw", RegWrite, 0);
        check("n_alusel", ALUSel, 0);
        check("n_pc", PC, 1);
        check("n_req", InstrReq, 1);

        // SUB then JZ +3, taken and not taken
        mem[0] = 8'h55;
        mem[1] = 8'hA3;
        ZF = 1'b1;
        restart();
        run_instr();
        check("jz_pc1", PC, 1);
        run_instr();
        check("jz_taken", PC, 5);
        ZF = 1'b0;
        restart();
        run_instr();
        run_instr();
        check("jz_not", PC, 2);

        // JC +2 at 0xFE wraps to 0x01
        clear_mem();
        mem[8'hFE] = 8'hB2;
        CF = 1'b1;
        restart();
        for (int i = 0; i < 254; i++) run_instr();
        check("pc_fe", PC, 8'hFE);
        run_instr();
        check("jc_wrap", PC, 8'h01);
        CF = 1'b0;

        // ALU op at 0xFF wraps to 0x00
        clear_mem();
        mem[8'hFF] = 8'h00;
        restart();
        for (int i = 0; i < 255; i++) run_instr();
        check("pc_ff", PC, 8'hFF);
        tick();
        tick();
        check("ff_wcz", WriteCZ, 1);
        tick();
        check("ff_wrap", PC, 8'h00);

        // Wait states then HALT at address 2
        clear_mem();
        mem[2] = 8'hF0;
        InstrValid = 1'b0;
        restart();
        nreq = 0;
        wsum = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (InstrReq) nreq++;
            wsum = wsum | WriteCZ;
            InstrValid = (i == 4);
            tick();
        end
        check("wait_req", nreq, 5);
        check("wait_wcz", wsum, 0);
        tick();
        tick();
        check("wait_pc", PC, 1);
        run_instr();
        tick();
        tick();
        tick();
        check("hlt_halt", Halted, 1);
        check("hlt_busy", Busy, 0);
        check("hlt_pc", PC, 2);
        tick();
        tick();
        check("hlt_frozen", PC, 2);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check("rs_pc", PC, 0);
        check("rs_req", InstrReq, 1);
        check("rs_halt", Halted, 0);

        // Start while busy is ignored
        clear_mem();
        InstrValid = 1'b1;
        restart();
        run_instr();
        InstrValid = 1'b0;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check("busy_start", PC, 1);
        InstrValid = 1'b1;

        // Reset during EXECUTE aborts
        mem[0] = 8'h46;
        restart();
        tick();
        tick();
        check("ab_wcz0", WriteCZ, 1);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        check("ab_pc", PC, 0);
        check("ab_wcz", WriteCZ, 0);
        check("ab_rw", RegWrite, 0);
        check("ab_busy", Busy, 0);
        tick();
        check("ab_idle", Busy, 0);
        Rst = 1'b1;
        Start = 1'b1;
        tick();
        Rst = 1'b0;
        Start = 1'b0;
        tick();
        check("rst_wins", Busy, 0);

        // Illegal opcode
        mem[0] = 8'hD0;
        restart();
        tick();
        tick();
        check("ill_pulse", IllegalOp, 1);
        check("ill_wcz", WriteCZ, 0);
        check("ill_rw", RegWrite, 0);
        tick();
        check("ill_clr", IllegalOp, 0);
        check("ill_pc", PC, 1);

`ifdef INSTR_TIMEOUT_EN
        InstrValid = 1'b0;
        restart();
        check("to_clr", FetchFault, 0);
        for (int i = 0; i < 15; i++) tick();
        check("to_busy", Busy, 1);
        tick();
        check("to_halt", Halted, 1);
        check("to_fault", FetchFault, 1);
        tick();
        check("to_sticky", FetchFault, 1);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check("to_start", FetchFault, 0);
        check("to_fetch", InstrReq, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
